alu_nibble_seq: RTL and testbench

ALU_NIBBLE_SEQ -- requirements
Module: alu_nibble_seq

---
 rtl/alu_nibble_seq.sv | 118 +++++++++++
 tb/tb_alu_nibble_seq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_nibble_seq.sv
// Nibble-serial W-bit ALU sequencer around an external 4-bit ALU slice.
// One nibble per cycle LSB first, carry rippled through a register between nibbles.
module alu_nibble_seq #(
    parameter int NIBBLES = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   req,
    input  logic [3:0]             op_s,
    input  logic                   op_m,
    input  logic                   op_cin_n,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    output logic [3:0]             alu_a,
    output logic [3:0]             alu_b,
    output logic [3:0]             alu_s,
    output logic                   alu_m,
    output logic                   alu_cn_n,
    input  logic [3:0]             alu_f,
    input  logic                   alu_cn4_n,
    input  logic                   alu_aeb,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   cout_n,
    output logic                   aeb
);

    localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state;
    logic [KW-1:0]           k;
    logic [KW-1:0]           kn;
    logic                    last;
    logic                    aeb_acc;
    logic [NIBBLES-1:0][3:0] opa, opb, res_w, res_next;

    assign kn   = k + KW'(1);
    assign last = (k == KW'(NIBBLES-1));

    // Working result is separate so the visible result only moves at completion.
    always_comb begin
        res_next    = res_w;
        res_next[k] = alu_f;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            k        <= '0;
            opa      <= '0;
            opb      <= '0;
            res_w    <= '0;
            aeb_acc  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            cout_n   <= 1'b1;
            aeb      <= 1'b0;
            alu_a    <= 4'd0;
            alu_b    <= 4'd0;
            alu_s    <= 4'd0;
            alu_m    <= 1'b1;
            alu_cn_n <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (req) begin
                        opa      <= a;
                        opb      <= b;
                        k        <= '0;
                        res_w    <= '0;
                        aeb_acc  <= 1'b1;
                        busy     <= 1'b1;
                        alu_a    <= a[3:0];
                        alu_b    <= b[3:0];
                        alu_s    <= op_s;
                        alu_m    <= op_m;
                        alu_cn_n <= op_cin_n;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    res_w   <= res_next;
                    aeb_acc <= aeb_acc & alu_aeb;
                    if (last) begin
                        result   <= res_next;
                        cout_n   <= alu_cn4_n;
                        aeb      <= aeb_acc & alu_aeb;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        alu_a    <= 4'd0;
                        alu_b    <= 4'd0;
                        alu_s    <= 4'd0;
                        alu_m    <= 1'b1;
                        alu_cn_n <= 1'b1;
                        state    <= DONE;
                    end else begin
                        // Slice carry-out becomes next nibble's carry-in, logic mode included.
                        k        <= kn;
                        alu_a    <= opa[kn];
                        alu_b    <= opb[kn];
                        alu_cn_n <= alu_cn4_n;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Directed bench for alu_nibble_seq with a behavioural 74181-style slice model.
module tb_alu_nibble_seq;

    localparam int N = 8;
    localparam int W = 4*N;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         req;
    logic [3:0]   op_s;
    logic         op_m;
    logic         op_cin_n;
    logic [W-1:0] a, b;
    logic [3:0]   alu_a, alu_b, alu_s, alu_f;
    logic         alu_m, alu_cn_n, alu_cn4_n, alu_aeb;
    logic         busy, done, cout_n, aeb;
    logic [W-1:0] result;

    int ncmp = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    alu_nibble_seq #(.NIBBLES(N)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .op_s(op_s), .op_m(op_m),
        .op_cin_n(op_cin_n), .a(a), .b(b), .alu_a(alu_a), .alu_b(alu_b),
        .alu_s(alu_s), .alu_m(alu_m), .alu_cn_n(alu_cn_n), .alu_f(alu_f),
        .alu_cn4_n(alu_cn4_n), .alu_aeb(alu_aeb), .busy(busy), .done(done),
        .result(result), .cout_n(cout_n), .aeb(aeb)
    );

    // Slice model: active-high data, active-low carries; only the functions used here.
    logic [4:0] sum;
    always_comb begin
        sum   = 5'd0;
        alu_f = 4'd0;
        case (alu_s)
            4'b1001: sum = {1'b0, alu_a} + {1'b0, alu_b}  + {4'd0, ~alu_cn_n};
            4'b0110: sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {4'd0, ~alu_cn_n};
            default: sum = {1'b0, alu_a};
        endcase
        if (alu_m) begin
            case (alu_s)
                4'b0110: alu_f = alu_a ^ alu_b;
                4'b1001: alu_f = ~(alu_a ^ alu_b);
                default: alu_f = alu_a;
            endcase
        end else begin
            alu_f = sum[3:0];
        end
    end
    assign alu_cn4_n = ~sum[4];
    assign alu_aeb   = &alu_f;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]   s;
        logic         m;
        logic         cin_n;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
        logic         co;
        logic         ae;
    } vec_t;

    vec_t tv[9];

    // Starts one operation and waits for done; lat = edges from accept edge to done.
    task automatic run_op(input logic [3:0] s, input logic m, input logic cin,
                          input logic [W-1:0] va, input logic [W-1:0] vb,
                          output int lat);
        @(negedge clk);
        op_s = s; op_m = m; op_cin_n = cin; a = va; b = vb; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        chk("busy_after_accept", 64'(busy), 64'd1);
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        int cyc;
        int ndone;
        int t[3];

        tv[0] = '{4'b1001, 1'b0, 1'b1, 32'h0000FFFF, 32'h00000001, 32'h00010000, 1'b1, 1'b0};
        tv[1] = '{4'b1001, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0};
        tv[2] = '{4'b0110, 1'b0, 1'b1, 32'h12345678, 32'h12345678, 32'hFFFFFFFF, 1'b1, 1'b1};
        tv[3] = '{4'b0110, 1'b0, 1'b1, 32'h12345678, 32'h12345679, 32'hFFFFFFFE, 1'b1, 1'b0};
        tv[4] = '{4'b0110, 1'b1, 1'b1, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b1, 1'b0};
        tv[5] = '{4'b1001, 1'b0, 1'b1, 32'h00000003, 32'h00000004, 32'h00000007, 1'b1, 1'b0};
        tv[6] = '{4'b1001, 1'b0, 1'b1, 32'h89ABCDEF, 32'h76543210, 32'hFFFFFFFF, 1'b1, 1'b1};
        tv[7] = '{4'b1001, 1'b0, 1'b0, 32'h7FFFFFFF, 32'h00000000, 32'h80000000, 1'b1, 1'b0};
        tv[8] = '{4'b1001, 1'b1, 1'b1, 32'h12345678, 32'h12345678, 32'hFFFFFFFF, 1'b1, 1'b1};

        reset_n = 1'b0; req = 1'b0; op_s = 4'd0; op_m = 1'b0; op_cin_n = 1'b1;
        a = '0; b = '0;
        #12;
        chk("rst_busy_done", {62'd0, busy, done}, 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_cout_aeb", {62'd0, cout_n, aeb}, 64'b10);
        chk("rst_alu_out", {49'd0, alu_a, alu_b, alu_s, alu_m, alu_cn_n, 1'b0},
            {49'd0, 12'd0, 1'b1, 1'b1, 1'b0});
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_op(tv[i].s, tv[i].m, tv[i].cin_n, tv[i].a, tv[i].b, lat);
            chk($sformatf("v%0d_latency", i), 64'(lat), 64'(N));
            chk($sformatf("v%0d_result", i), 64'(result), 64'(tv[i].r));
            chk($sformatf("v%0d_cout_n", i), 64'(cout_n), 64'(tv[i].co));
            chk($sformatf("v%0d_aeb", i), 64'(aeb), 64'(tv[i].ae));
            chk($sformatf("v%0d_busy_at_done", i), 64'(busy), 64'd0);
            @(posedge clk); #1;
            chk($sformatf("v%0d_done_one_cycle", i), 64'(done), 64'd0);
        end

        // Logic-mode carry chain visible on alu_cn_n; operands changed mid-run.
        @(negedge clk);
        op_s = 4'b0110; op_m = 1'b1; op_cin_n = 1'b1;
        a = 32'hF0F0F0F0; b = 32'hFF00FF00; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0; a = 32'h0; b = 32'hFFFFFFFF;
        chk("xor_k0_cn", 64'(alu_cn_n), 64'd1);
        @(posedge clk); #1;
        chk("xor_k1_alu_a", 64'(alu_a), 64'hF);
        chk("xor_k1_alu_m", 64'(alu_m), 64'd1);
        @(posedge clk); #1;
        chk("xor_k2_cn", 64'(alu_cn_n), 64'd0);
        chk("xor_result_held", 64'(result), 64'(tv[8].r));
        cyc = 0;
        while (!done && cyc < 40) begin @(posedge clk); #1; cyc++; end
        chk("xor_result", 64'(result), 64'h0FF00FF0);
        @(posedge clk); #1;

        // Back-to-back with req held high.
        @(negedge clk);
        op_s = 4'b1001; op_m = 1'b0; op_cin_n = 1'b1; a = 32'd1; b = 32'd2; req = 1'b1;
        ndone = 0; cyc = 0;
        while (ndone < 3 && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            if (done) begin t[ndone] = cyc; ndone++; end
        end
        req = 1'b0;
        chk("b2b_count", 64'(ndone), 64'd3);
        chk("b2b_first", 64'(t[0]), 64'(N+1));
        chk("b2b_gap1", 64'(t[1] - t[0]), 64'(N+2));
        chk("b2b_gap2", 64'(t[2] - t[1]), 64'(N+2));
        chk("b2b_result", 64'(result), 64'd3);
        @(posedge clk); #1;

        // req pulses while busy must not start another operation.
        @(negedge clk);
        a = 32'd5; b = 32'd6; req = 1'b1;
        @(negedge clk); req = 1'b0;
        @(negedge clk); req = 1'b1;
        @(negedge clk); req = 1'b0;
        ndone = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("busy_req_ignored", 64'(ndone), 64'd1);
        chk("busy_req_result", 64'(result), 64'd11);

        // Reset at k=4 abandons the operation.
        @(negedge clk);
        a = 32'h0000FFFF; b = 32'd1; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        reset_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_result", 64'(result), 64'd0);
        chk("midrst_alu", {58'd0, alu_a, alu_m, alu_cn_n}, {58'd0, 4'd0, 1'b1, 1'b1});
        @(negedge clk);
        reset_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (done || busy) ndone++;
        end
        chk("midrst_no_done", 64'(ndone), 64'd0);
        run_op(4'b1001, 1'b0, 1'b1, 32'd3, 32'd4, lat);
        chk("postrst_latency", 64'(lat), 64'(N));
        chk("postrst_result", 64'(result), 64'd7);
        chk("postrst_cout_n", 64'(cout_n), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
